// File: rtl/tone_synth.sv
// tone_synth
//   Square-wave tone generator with an attack/release envelope. It streams
//   24-bit stereo samples into the audio codec write FIFO. One accepted write
//   is one sample period, and the codec is fed zeros while no tone plays.
//
//   Build option: define TONE_RAMP_EN for linear attack/release ramps of
//   RAMP_STEP per sample. Without it, the envelope jumps between 0 and
//   AMPLITUDE in a single write.
module tone_synth #(
    parameter int SAMPLE_RATE = 48000,
    parameter int AMPLITUDE   = 1000000,
    parameter int RAMP_STEP   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] freq,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    localparam logic [21:0] RATE_W = 22'(SAMPLE_RATE);
    localparam logic [31:0] AMP_W  = 32'(AMPLITUDE);
    localparam logic [23:0] AMP_24 = 24'(AMPLITUDE);
`ifdef TONE_RAMP_EN
    localparam logic [31:0] STEP_W = 32'(RAMP_STEP);
`else
    // Any step of at least the full amplitude turns each ramp into a single write.
    localparam logic [31:0] STEP_W = (RAMP_STEP > AMPLITUDE) ? 32'(RAMP_STEP) : 32'(AMPLITUDE);
`endif

    // Envelope step up, saturating at the peak amplitude.
    function automatic logic [23:0] ramp_up(input logic [23:0] a);
        logic [31:0] sum_v;
        sum_v = {8'd0, a} + STEP_W;
        if (sum_v >= AMP_W) begin
            return AMP_24;
        end else begin
            return sum_v[23:0];
        end
    endfunction

    // Envelope step down, saturating at zero.
    function automatic logic [23:0] ramp_down(input logic [23:0] a);
        logic [31:0] dif_v;
        if ({8'd0, a} <= STEP_W) begin
            return 24'd0;
        end else begin
            dif_v = {8'd0, a} - STEP_W;
            return dif_v[23:0];
        end
    endfunction

    // Square-wave sample: +amp on the high half, -amp on the low half.
    function automatic logic [23:0] make_sample(input logic [23:0] a, input logic p, input logic silent);
        if (silent) begin
            return 24'd0;
        end else if (p) begin
            return a;
        end else begin
            return 24'd0 - a;
        end
    endfunction

    env_state_t  state_r, state_s;
    logic [23:0] amp_r, amp_s;
    logic [20:0] acc_r, acc_s;
    logic        pol_r, pol_s;
    logic        write_r;
    logic [23:0] data_r, data_s;
    logic        busy_r;
    logic [21:0] step2_s, nxt_s;
    logic        mute_s;
    logic [23:0] up_s, down_s;

    // Next oscillator, envelope and sample values for the write being accepted.
    always_comb begin
        state_s = state_r;
        amp_s   = amp_r;
        acc_s   = acc_r;
        pol_s   = pol_r;
        step2_s = {1'b0, freq, 1'b0};
        nxt_s   = {1'b0, acc_r} + step2_s;
        mute_s  = (freq == 20'd0) || (step2_s >= RATE_W);
        up_s    = ramp_up(amp_r);
        down_s  = ramp_down(amp_r);

        // Phase accumulator; a muted frequency freezes the phase.
        if (mute_s) begin
            acc_s = acc_r;
            pol_s = pol_r;
        end else if (nxt_s >= RATE_W) begin
            acc_s = 21'(nxt_s - RATE_W);
            pol_s = ~pol_r;
        end else begin
            acc_s = nxt_s[20:0];
            pol_s = pol_r;
        end

        // Envelope; an enable change wins over reaching the peak or zero.
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_ATTACK;
                    amp_s   = ramp_up(24'd0);
                    acc_s   = 21'd0;
                    pol_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                    amp_s   = 24'd0;
                end
            end
            ST_ATTACK: begin
                if (!enable) begin
                    state_s = ST_RELEASE;
                end else begin
                    amp_s = up_s;
                    if (up_s == AMP_24) begin
                        state_s = ST_SUSTAIN;
                    end else begin
                        state_s = ST_ATTACK;
                    end
                end
            end
            ST_SUSTAIN: begin
                amp_s = AMP_24;
                if (!enable) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_SUSTAIN;
                end
            end
            ST_RELEASE: begin
                if (enable) begin
                    state_s = ST_ATTACK;
                end else begin
                    amp_s = down_s;
                    if (down_s == 24'd0) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                amp_s   = 24'd0;
            end
        endcase

        data_s = make_sample(amp_s, pol_s, mute_s || (state_s == ST_IDLE));
    end

    // Write strobe: at most one write every other cycle while the FIFO has room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r <= 1'b0;
        end else begin
            write_r <= write_ready & ~write_r;
        end
    end

    // Envelope, oscillator and output sample advance only on accepted writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            amp_r   <= 24'd0;
            acc_r   <= 21'd0;
            pol_r   <= 1'b0;
            data_r  <= 24'd0;
            busy_r  <= 1'b0;
        end else if (write_r) begin
            state_r <= state_s;
            amp_r   <= amp_s;
            acc_r   <= acc_s;
            pol_r   <= pol_s;
            data_r  <= data_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign write           = write_r;
    assign writedata_left  = data_r;
    assign writedata_right = data_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed, table-driven bench for tone_synth.
// Expected values follow the build option TONE_RAMP_EN (linear 4096 steps)
// or its absence (single-write jumps to/from full amplitude).
module tb_tone_synth;

    localparam int AMP = 1000000;
`ifdef TONE_RAMP_EN
    localparam int STEP = 4096;
`else
    localparam int STEP = 1000000;
`endif
    localparam int NREL = (AMP + STEP - 1) / STEP;

    typedef struct {
        logic        en;
        logic [19:0] f;
        logic [23:0] d;
        logic        b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] freq;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        busy;

    int          n_pass  = 0;
    int          n_total = 0;
    vec_t        vecs[6];
    logic [23:0] d_v;
    logic        b_v;
    logic        ok_v;
    int          cnt;
    int          nz;
    int          amp_v;

    tone_synth dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .freq           (freq),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic int amin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [23:0] signed_amp(input int a, input logic p);
        return p ? 24'(a) : 24'(-a);
    endfunction

    // Polarity seen on write m of a 1000 Hz tone started from idle.
    function automatic logic pol_at(input int m);
        return 1'(((m - 1) / 24) % 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for the next write, capture it, then step into the gap cycle so
    // inputs changed by the caller are sampled by the following write.
    task automatic next_write(output logic [23:0] d, output logic b, output logic ok);
        ok = 1'b0;
        d  = 24'd0;
        b  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (write === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL write_timeout: no write within 8 cycles");
        end else begin
            d = writedata_left;
            b = busy;
            check("left_eq_right", 32'(writedata_right), 32'(writedata_left));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic observe(input string name, input logic [23:0] exp_d, input logic exp_b);
        logic [23:0] d;
        logic        b;
        logic        ok;
        next_write(d, b, ok);
        if (ok) begin
            check({name, "_data"}, 32'(d), 32'(exp_d));
            check({name, "_busy"}, 32'(b), 32'(exp_b));
        end
    endtask

    task automatic mute_test(input logic [19:0] f);
        logic [23:0] d;
        logic        b;
        logic        ok;
        int          c;
        int          z;
        freq   = f;
        enable = 1'b1;
        observe("mute_start", 24'd0, 1'b0);
        for (int m = 1; m <= NREL + 3; m++) begin
            observe("mute_tone", 24'd0, 1'b1);
        end
        enable = 1'b0;
        c = 0;
        z = 0;
        for (int i = 0; i < NREL + 20; i++) begin
            next_write(d, b, ok);
            if (!ok) break;
            c++;
            if (d != 24'd0) z++;
            if (b == 1'b0) break;
        end
        check("mute_release_len", 32'(c), 32'(NREL + 2));
        check("mute_release_zero", 32'(z), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        freq        = 20'd0;
        write_ready = 1'b0;

        vecs[0] = '{1'b0, 20'd1000, 24'd0, 1'b0};
        vecs[1] = '{1'b0, 20'd1000, 24'd0, 1'b0};
        vecs[2] = '{1'b1, 20'd1000, 24'd0, 1'b0};
        vecs[3] = '{1'b1, 20'd1000, signed_amp(amin(1 * STEP, AMP), 1'b0), 1'b1};
        vecs[4] = '{1'b1, 20'd1000, signed_amp(amin(2 * STEP, AMP), 1'b0), 1'b1};
        vecs[5] = '{1'b1, 20'd1000, signed_amp(amin(3 * STEP, AMP), 1'b0), 1'b1};

        // Reset state.
        #12;
        check("rst_write", 32'(write), 32'd0);
        check("rst_left", 32'(writedata_left), 32'd0);
        check("rst_right", 32'(writedata_right), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        write_ready = 1'b1;

        // Idle feed: strobe alternates, data zero.
        next_write(d_v, b_v, ok_v);
        check("idle_first_data", 32'(d_v), 32'd0);
        check("strobe_gap", 32'(write), 32'd0);
        @(posedge clk);
        #1;
        check("strobe_next", 32'(write), 32'd1);
        @(posedge clk);
        #1;

        // Tone start from the table.
        for (int i = 0; i < 6; i++) begin
            enable = vecs[i].en;
            freq   = vecs[i].f;
            observe($sformatf("vec%0d", i), vecs[i].d, vecs[i].b);
        end

        // Attack into sustain at 1000 Hz, with a 50-cycle stall mid-tone.
        for (int m = 4; m <= 300; m++) begin
            observe("tone", signed_amp(amin(m * STEP, AMP), pol_at(m)), 1'b1);
            if (m == 100) begin
                write_ready = 1'b0;
                cnt = 0;
                for (int c = 0; c < 50; c++) begin
                    @(posedge clk);
                    #1;
                    if (write === 1'b1) cnt++;
                end
                check("stall_no_write", 32'(cnt), 32'd0);
                write_ready = 1'b1;
            end
        end

        // Release from sustain down to idle.
        enable = 1'b0;
        observe("rel_first", signed_amp(AMP, pol_at(301)), 1'b1);
        observe("rel_hold", signed_amp(AMP, pol_at(302)), 1'b1);
        for (int i = 1; i <= NREL; i++) begin
            amp_v = AMP - i * STEP;
            if (amp_v < 0) amp_v = 0;
            observe("rel_ramp", (amp_v == 0) ? 24'd0 : signed_amp(amp_v, pol_at(302 + i)), amp_v != 0);
        end
        observe("rel_idle", 24'd0, 1'b0);

        // Muted frequencies.
        mute_test(20'd24000);
        mute_test(20'd0);

        // Asynchronous reset during sustain.
        freq   = 20'd1000;
        enable = 1'b1;
        observe("rst_tone_start", 24'd0, 1'b0);
        for (int m = 1; m <= NREL + 3; m++) begin
            observe("rst_tone", signed_amp(amin(m * STEP, AMP), pol_at(m)), 1'b1);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_write", 32'(write), 32'd0);
        check("async_rst_left", 32'(writedata_left), 32'd0);
        check("async_rst_right", 32'(writedata_right), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        observe("post_rst_first", 24'd0, 1'b0);
        observe("post_rst_second", signed_amp(amin(STEP, AMP), 1'b0), 1'b1);
        enable = 1'b0;
        b_v = 1'b1;
        for (int i = 0; i < NREL + 10; i++) begin
            next_write(d_v, b_v, ok_v);
            if (!ok_v || b_v == 1'b0) break;
        end
        check("post_rst_idle", 32'(b_v), 32'd0);

`ifdef TONE_RAMP_EN
        // Retrigger during release near half amplitude: no phase reset.
        enable = 1'b1;
        observe("retrig_start", 24'd0, 1'b0);
        for (int m = 1; m <= 250; m++) begin
            observe("retrig_attack", signed_amp(amin(m * STEP, AMP), pol_at(m)), 1'b1);
        end
        enable = 1'b0;
        observe("retrig_drop", signed_amp(AMP, pol_at(251)), 1'b1);
        for (int m = 252; m <= 373; m++) begin
            observe("retrig_rel", signed_amp(AMP - (m - 252) * STEP, pol_at(m)), 1'b1);
        end
        enable = 1'b1;
        observe("retrig_turn", signed_amp(AMP - 122 * STEP, pol_at(374)), 1'b1);
        for (int m = 375; m <= 380; m++) begin
            observe("retrig_rise", signed_amp(AMP - 122 * STEP + (m - 375) * STEP, pol_at(m)), 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
